// File: rtl/ex_wb_port_arbiter_pkg.sv
// Shared definitions for the execute-stage writeback port arbiter:
// GPR ID/value widths, the "no register" ID and a small helper.
package ex_wb_port_arbiter_pkg;

    localparam int GPR_ID_W  = 7;
    localparam int GPR_VAL_W = 64;

    localparam logic [GPR_ID_W-1:0] JX2_GR_ZZR = 7'h7F;

    typedef struct packed {
        logic [GPR_ID_W-1:0]  id;
        logic [GPR_VAL_W-1:0] val;
    } gpr_wr_t;

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/ex_wb_port_arbiter_pendbuf.sv
// In-order pending-write buffer: circular storage with multi-push, multi-pop,
// a view of the oldest NWPORT entries, and an age-ordered forwarding search.
module ex_wb_pendbuf
    import ex_wb_port_arbiter_pkg::*;
#(
    parameter int NLANE  = 3,
    parameter int NWPORT = 2,
    parameter int DEPTH  = 6
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [2:0]                    pop_cnt,
    input  logic [2:0]                    push_cnt,
    input  logic [NLANE*GPR_ID_W-1:0]     push_id,
    input  logic [NLANE*GPR_VAL_W-1:0]    push_val,
    output logic [NWPORT*GPR_ID_W-1:0]    head_id,
    output logic [NWPORT*GPR_VAL_W-1:0]   head_val,
    output logic [2:0]                    count,
    input  logic [GPR_ID_W-1:0]           query_id,
    output logic                          query_hit,
    output logic [GPR_VAL_W-1:0]          query_val
);

    localparam int PW = $clog2(DEPTH);

    logic [GPR_ID_W-1:0]  ent_id  [DEPTH];
    logic [GPR_VAL_W-1:0] ent_val [DEPTH];
    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;

    // Offsets never exceed DEPTH-1, so a single conditional subtract suffices.
    function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= DEPTH)
            s = s - DEPTH;
        return PW'(s);
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++)
                ent_id[i] <= JX2_GR_ZZR;
        end else begin
            for (int k = 0; k < NLANE; k++)
                if (k < int'(push_cnt))
                    ent_id[wrap(tail, k)] <= push_id[k*GPR_ID_W +: GPR_ID_W];
            head  <= wrap(head, int'(pop_cnt));
            tail  <= wrap(tail, int'(push_cnt));
            count <= count - pop_cnt + push_cnt;
        end
    end

    always_ff @(posedge clock) begin
        for (int k = 0; k < NLANE; k++)
            if (k < int'(push_cnt))
                ent_val[wrap(tail, k)] <= push_val[k*GPR_VAL_W +: GPR_VAL_W];
    end

    always_comb begin
        head_id  = {NWPORT{JX2_GR_ZZR}};
        head_val = '0;
        for (int i = 0; i < NWPORT; i++) begin
            if (i < int'(count)) begin
                head_id[i*GPR_ID_W +: GPR_ID_W]    = ent_id[wrap(head, i)];
                head_val[i*GPR_VAL_W +: GPR_VAL_W] = ent_val[wrap(head, i)];
            end
        end
    end

    // Walk oldest to newest from head so the last match is the newest write.
    always_comb begin
        query_hit = 1'b0;
        query_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(count) && ent_id[wrap(head, i)] == query_id) begin
                query_hit = 1'b1;
                query_val = ent_val[wrap(head, i)];
            end
        end
    end

endmodule

// File: rtl/ex_wb_port_arbiter.sv
// Writeback port arbiter: buffered entries first, then valid lanes in order,
// fill the write ports; leftovers queue up and a hold throttles the lanes.
module ex_wb_port_arbiter
    import ex_wb_port_arbiter_pkg::*;
#(
    parameter int NLANE  = 3,
    parameter int NWPORT = 2,
    parameter int DEPTH  = 6
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NLANE*GPR_ID_W-1:0]     laneId,
    input  logic [NLANE*GPR_VAL_W-1:0]    laneVal,
    output logic [NWPORT*GPR_ID_W-1:0]    portId,
    output logic [NWPORT*GPR_VAL_W-1:0]   portVal,
    output logic                          exHold,
    input  logic [GPR_ID_W-1:0]           fwdId,
    output logic                          fwdHit,
    output logic [GPR_VAL_W-1:0]          fwdVal,
    output logic [2:0]                    pendCount
);

    logic [NWPORT*GPR_ID_W-1:0]  head_id;
    logic [NWPORT*GPR_VAL_W-1:0] head_val;
    logic [2:0]                  buf_count;
    logic                        buf_hit;
    logic [GPR_VAL_W-1:0]        buf_val;

    logic [2:0]                  pop_cnt;
    logic [2:0]                  push_cnt;
    logic [NLANE*GPR_ID_W-1:0]   push_id;
    logic [NLANE*GPR_VAL_W-1:0]  push_val;

    logic [NLANE-1:0]            lane_ok;
    int                          rank [NLANE];
    int                          n_valid;
    int                          n_pop;
    int                          n_lane_port;
    int                          n_push;
    int                          count_next;

    logic [NWPORT*GPR_ID_W-1:0]  port_id_p0;
    logic [NWPORT*GPR_VAL_W-1:0] port_val_p0;
    logic                        hold_p0;

    ex_wb_pendbuf #(
        .NLANE  (NLANE),
        .NWPORT (NWPORT),
        .DEPTH  (DEPTH)
    ) u_pendbuf (
        .clock     (clock),
        .reset     (reset),
        .pop_cnt   (pop_cnt),
        .push_cnt  (push_cnt),
        .push_id   (push_id),
        .push_val  (push_val),
        .head_id   (head_id),
        .head_val  (head_val),
        .count     (buf_count),
        .query_id  (fwdId),
        .query_hit (buf_hit),
        .query_val (buf_val)
    );

    always_comb begin
        lane_ok = '0;
        n_valid = 0;
        for (int l = 0; l < NLANE; l++) begin
            rank[l] = n_valid;
            if (!exHold && laneId[l*GPR_ID_W +: GPR_ID_W] != JX2_GR_ZZR) begin
                lane_ok[l] = 1'b1;
                n_valid    = n_valid + 1;
            end
        end

        // Buffered entries are strictly older, so they always win the ports first.
        n_pop       = min_int(int'(buf_count), NWPORT);
        n_lane_port = min_int(NWPORT - n_pop, n_valid);
        n_push      = n_valid - n_lane_port;
        count_next  = int'(buf_count) + n_valid - n_pop - n_lane_port;
        hold_p0     = (DEPTH - count_next) < NLANE;
        pop_cnt     = 3'(n_pop);
        push_cnt    = 3'(n_push);

        port_id_p0  = {NWPORT{JX2_GR_ZZR}};
        port_val_p0 = '0;
        for (int p = 0; p < NWPORT; p++) begin
            if (p < n_pop) begin
                port_id_p0[p*GPR_ID_W +: GPR_ID_W]    = head_id[p*GPR_ID_W +: GPR_ID_W];
                port_val_p0[p*GPR_VAL_W +: GPR_VAL_W] = head_val[p*GPR_VAL_W +: GPR_VAL_W];
            end else begin
                for (int l = 0; l < NLANE; l++) begin
                    if (lane_ok[l] && rank[l] == p - n_pop && (p - n_pop) < n_lane_port) begin
                        port_id_p0[p*GPR_ID_W +: GPR_ID_W]    = laneId[l*GPR_ID_W +: GPR_ID_W];
                        port_val_p0[p*GPR_VAL_W +: GPR_VAL_W] = laneVal[l*GPR_VAL_W +: GPR_VAL_W];
                    end
                end
            end
        end

        push_id  = {NLANE{JX2_GR_ZZR}};
        push_val = '0;
        for (int k = 0; k < NLANE; k++) begin
            for (int l = 0; l < NLANE; l++) begin
                if (k < n_push && lane_ok[l] && rank[l] == n_lane_port + k) begin
                    push_id[k*GPR_ID_W +: GPR_ID_W]    = laneId[l*GPR_ID_W +: GPR_ID_W];
                    push_val[k*GPR_VAL_W +: GPR_VAL_W] = laneVal[l*GPR_VAL_W +: GPR_VAL_W];
                end
            end
        end
    end

    // ---- stage boundary: write-port and hold registers ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            portId  <= {NWPORT{JX2_GR_ZZR}};
            portVal <= '0;
            exHold  <= 1'b0;
        end else begin
            portId  <= port_id_p0;
            portVal <= port_val_p0;
            exHold  <= hold_p0;
        end
    end

    assert property (@(posedge clock) disable iff (!reset) count_next <= DEPTH);

    // Buffer entries are younger than anything already on a port.
    always_comb begin
        fwdHit = 1'b0;
        fwdVal = '0;
        for (int p = 0; p < NWPORT; p++) begin
            if (portId[p*GPR_ID_W +: GPR_ID_W] == fwdId) begin
                fwdHit = 1'b1;
                fwdVal = portVal[p*GPR_VAL_W +: GPR_VAL_W];
            end
        end
        if (buf_hit) begin
            fwdHit = 1'b1;
            fwdVal = buf_val;
        end
        if (fwdId == JX2_GR_ZZR) begin
            fwdHit = 1'b0;
            fwdVal = '0;
        end
    end

    assign pendCount = buf_count;

endmodule

// File: doc/ex_wb_port_arbiter.md
Name: ex_wb_port_arbiter

Overview:
- Shares the register-file write ports among the execute lanes' final-stage destination outputs (regIdRn2/regValRn2 per lane).
- Writes that cannot get a port in the current cycle go into a small in-order pending buffer.
- The block raises a pipeline hold when the buffer could not absorb a worst-case cycle.
- It also answers forwarding lookups against writes that are buffered but not yet committed.

Parameters:
- NLANE, 3, number of execute lanes presenting writebacks.
- NWPORT, 2, number of register-file write ports.
- DEPTH, 6, pending-buffer entries; must be at least NLANE+NWPORT.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- laneId  in  NLANE*7  per-lane destination GPR ID; JX2_GR_ZZR means no write.
- laneVal  in  NLANE*64  per-lane destination value.
- portId  out  NWPORT*7  registered write-port IDs; ZZR means idle.
- portVal  out  NWPORT*64  registered write-port values.
- exHold  out  1  registered pipeline hold request.
- fwdId  in  7  forwarding query ID.
- fwdHit  out  1  query matches a pending or in-flight write (combinational).
- fwdVal  out  64  value of the newest matching write.
- pendCount  out  3  current buffer occupancy, for debug and performance counters.

Behaviour:
- Reset (asynchronous, active-low):
  - count=0, exHold=0.
  - all portId=ZZR, portVal=0.
  - buffer IDs=ZZR.
- Lane capture:
  - When exHold is high, lane inputs are ignored; the pipeline is frozen and re-presents the same values.
  - Otherwise a lane is valid iff laneId != ZZR.
- Per-cycle ordering:
  - The ordered candidate list is buffer entries oldest to newest, then valid lanes 0..NLANE-1.
  - The first min(NWPORT, list length) candidates go to ports 0..NWPORT-1 at the next clock edge.
  - Remaining candidates are appended to the buffer in list order.
  - count_next = count + N_valid - served.
- No bypass: a lane write never takes a port while an older buffered entry waits. Program order is preserved, so the last writer to an ID always commits last.
- Duplicate IDs:
  - Same-ID writes in one cycle both commit, in lane order.
  - When two ports write the same ID in one cycle, the higher port index is the later write. The register file must give the higher port index priority.
- Hold:
  - exHold_next = (DEPTH - count_next) < NLANE.
  - Guarantee: whenever exHold is low, count <= DEPTH-NLANE. An overflow is therefore impossible.
  - An assertion flags count_next > DEPTH.
- Hold release: while exHold is high the buffer drains NWPORT entries per cycle. exHold drops on the cycle after count_next <= DEPTH-NLANE.
- Port latency: one cycle from lane presentation, or from the entry reaching the buffer head, to portId/portVal. Unused ports drive ZZR.
- Forwarding:
  - fwdHit=1 if fwdId != ZZR and fwdId matches a port output register or a buffer entry.
  - fwdVal comes from the newest match: the newest buffer entry first, then the highest-index port register.
  - Current-cycle lane inputs are not searched; the existing EX-stage forwarding already covers them.
- Branch flush: needs no input here. Flushed lanes already present ZZR, and buffered entries are committed work that is never dropped.
- Buffer: storage is a circular buffer with head/tail pointers modulo DEPTH. Wrap-around must keep age order for the forwarding search.

Decomposition:
- Shared defs (CoreDefs): JX2_GR_ZZR, GPR ID width (7), GPR value width (64).
- One natural sub-module: ex_wb_pendbuf holds the circular buffer, multi-push and multi-pop, and the age-ordered CAM search for forwarding.
- Arbitration and hold logic stay in the top level.

Test Plan:
- Reset mid-stream: lanes write R5=0x11, R6=0x22, R7=0x33, then reset is pulsed low asynchronously. Required: portId=ZZR, exHold=0, pendCount=0 immediately, with no writes after reset release.
- Two writes: lanes 0 and 1 write R1=0xA and R2=0xB, lane 2 is ZZR. Required: the next cycle has port0=R1/0xA and port1=R2/0xB, and pendCount=0.
- Overflow into buffer: three lanes write R1, R2, R3 for 2 cycles. Required, cycle-by-cycle:
  - pendCount goes 1 then 2.
  - Ports commit R1,R2 then R3(old),R1.
  - exHold stays 0 until DEPTH - count < 3.
- Hold engage/release: sustain three writes per cycle until exHold rises. Required:
  - count never exceeds 6.
  - Lane inputs during hold are not double-committed.
  - exHold falls once count <= 3.
- Ordering and forwarding: lane 2 writes R9=0x1 in cycle n and lane 0 writes R9=0x2 in cycle n+1, with the buffer non-empty. Required:
  - R9=0x1 commits strictly before R9=0x2.
  - With fwdId=R9, fwdVal is 0x2 once the second write is pending.
  - fwdHit=0 after both commit.
- ZZR query: fwdId=ZZR while the buffer holds ZZR-free entries. Required: fwdHit=0.
